tap_controller: RTL

//  IEEE 1149.1 TAP state machine plus instruction register and 1-bit bypass register.

---
 rtl/tap_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tap_controller
//  Description : IEEE 1149.1 TAP state machine with instruction register and
//                1-bit bypass register. Drives the DR strobes of a downstream
//                ID register and muxes TDO from IR, bypass or ID register.
//  Revision    : 1.0  initial release
// ============================================================================
module tap_controller #(
    parameter int              IR_W      = 4,
    parameter logic [IR_W-1:0] IDCODE_OP = {{(IR_W-1){1'b0}}, 1'b1},
    parameter logic [IR_W-1:0] BYPASS_OP = {IR_W{1'b1}}
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            idr_tdo,
    output logic            TDO,
    output logic            TDO_en,
    output logic            CaptureDR,
    output logic            ShiftDR,
    output logic            UpdateDR,
    output logic            CaptureIR,
    output logic            ShiftIR,
    output logic            UpdateIR,
    output logic            TLR,
    output logic            sel_idcode,
    output logic            sel_bypass,
    output logic [IR_W-1:0] ir_value,
    output logic [3:0]      state
);

    // Value parallel-loaded into the IR shifter in Capture-IR (...01)
    localparam logic [IR_W-1:0] c_IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};

    // Encoding is fixed by the standard's debug view of the TAP
    typedef enum logic [3:0] {
        S_TLR     = 4'hF,
        S_RTI     = 4'hC,
        S_SEL_DR  = 4'h7,
        S_CAP_DR  = 4'h6,
        S_SH_DR   = 4'h2,
        S_EX1_DR  = 4'h1,
        S_PAU_DR  = 4'h3,
        S_EX2_DR  = 4'h0,
        S_UPD_DR  = 4'h5,
        S_SEL_IR  = 4'h4,
        S_CAP_IR  = 4'hE,
        S_SH_IR   = 4'hA,
        S_EX1_IR  = 4'h9,
        S_PAU_IR  = 4'hB,
        S_EX2_IR  = 4'h8,
        S_UPD_IR  = 4'hD
    } tap_state_t;

    tap_state_t      r_state;
    tap_state_t      w_next;
    logic [IR_W-1:0] r_ir_shift;
    logic [IR_W-1:0] r_ir_value;
    logic            r_bypass;
    logic            w_sel_idcode;
    logic            w_sel_bypass;

    // TAP state register; TRST returns to Test-Logic-Reset immediately
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode from TMS
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = TMS ? S_TLR    : S_RTI;
            S_RTI:    w_next = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = TMS ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    // IR shifter: capture ...01, shift right with TDI entering the MSB
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_shift <= '0;
        end else if (r_state == S_CAP_IR) begin
            r_ir_shift <= c_IR_CAPTURE;
        end else if (r_state == S_SH_IR) begin
            r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
        end
    end

    // Active instruction: only Update-IR or Test-Logic-Reset may change it
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir_value <= IDCODE_OP;
        end else if (r_state == S_UPD_IR) begin
            r_ir_value <= r_ir_shift;
        end else if (r_state == S_TLR) begin
            r_ir_value <= IDCODE_OP;
        end
    end

    // Single-bit bypass register, active only while bypass is selected
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass && (r_state == S_CAP_DR)) begin
            r_bypass <= 1'b0;
        end else if (w_sel_bypass && (r_state == S_SH_DR)) begin
            r_bypass <= TDI;
        end
    end

    // Anything other than IDCODE (explicit BYPASS or undefined) selects bypass
    assign w_sel_idcode = (r_ir_value == IDCODE_OP);
    assign w_sel_bypass = !w_sel_idcode || (r_ir_value == BYPASS_OP);

    // Strobes decoded straight from the registered state
    assign TLR        = (r_state == S_TLR);
    assign CaptureDR  = (r_state == S_CAP_DR);
    assign ShiftDR    = (r_state == S_SH_DR);
    assign UpdateDR   = (r_state == S_UPD_DR);
    assign CaptureIR  = (r_state == S_CAP_IR);
    assign ShiftIR    = (r_state == S_SH_IR);
    assign UpdateIR   = (r_state == S_UPD_IR);
    assign TDO_en     = ShiftDR || ShiftIR;
    assign sel_idcode = w_sel_idcode;
    assign sel_bypass = w_sel_bypass;
    assign ir_value   = r_ir_value;
    assign state      = r_state;

    // Serial output mux
    always_comb begin
        TDO = 1'b0;
        if (r_state == S_SH_IR) begin
            TDO = r_ir_shift[0];
        end else if (r_state == S_SH_DR) begin
            TDO = w_sel_idcode ? idr_tdo : r_bypass;
        end
    end

endmodule
`default_nettype wire
